// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared types and field constants for the instruction encoder
package encoder_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_ILL = 2'b11
    } OpKind;

    typedef enum logic [1:0] {
        ERR_BADOP = 2'b00,
        ERR_IMM   = 2'b01,
        ERR_RANGE = 2'b10,
        ERR_FULL  = 2'b11
    } ErrCode;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_EMIT,
        ST_ERR
    } EncState;

    localparam logic [1:0] DP_CLASS  = 2'b00;
    localparam logic [1:0] MEM_CLASS = 2'b01;
    // Immediate offset, pre-indexed, add, word, no writeback; L is OR-ed into bit 0
    localparam logic [5:0] MEM_PUBW  = 6'b011000;
    localparam logic [3:0] BR_FIXED  = 4'b1010;

    typedef struct packed {
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        sBit;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [31:0] imm32;
    } DpFields;

    function automatic logic [31:0] encodeDp(input logic [3:0] cond, input logic immFlag,
                                             input logic [3:0] cmd, input logic sBit,
                                             input logic [3:0] rn, input logic [3:0] rd,
                                             input logic [11:0] src2);
        return {cond, DP_CLASS, immFlag, cmd, sBit, rn, rd, src2};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - loader field bundle plus instruction-memory write port
interface instr_encoder_if #(parameter int ADDR_W = 6);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [3:0]        cmd;
    logic [3:0]        cond;
    logic              s_bit;
    logic              ld;
    logic              use_imm;
    logic [3:0]        rd;
    logic [3:0]        rn;
    logic [3:0]        rm;
    logic [31:0]       imm32;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              err;
    logic [1:0]        err_code;
    logic              full;

    modport master (
        output in_valid, op, cmd, cond, s_bit, ld, use_imm, rd, rn, rm, imm32,
        input  in_ready, wr_en, wr_addr, wr_data, err, err_code, full
    );

    modport slave (
        input  in_valid, op, cmd, cond, s_bit, ld, use_imm, rd, rn, rm, imm32,
        output in_ready, wr_en, wr_addr, wr_data, err, err_code, full
    );
endinterface

// File: rtl/instr_encoder_imm_rot_check.sv
// rtl/instr_encoder_imm_rot_check.sv - tests one even rotation of a DP immediate for an 8-bit fit
module imm_rot_check (
    input  logic [31:0] imm32,
    input  logic [3:0]  k,
    output logic        hit,
    output logic [7:0]  imm8
);
    logic [5:0]  shiftAmt;
    logic [31:0] rotated;

    // k=0 gives a 32-bit right shift, which yields zero and leaves the value unrotated
    assign shiftAmt = {1'b0, k, 1'b0};
    assign rotated  = (imm32 << shiftAmt) | (imm32 >> (6'd32 - shiftAmt));
    assign hit      = ~|rotated[31:8];
    assign imm8     = rotated[7:0];
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - turns field bundles into ARM-subset words and writes them sequentially
module instr_encoder
    import encoder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input logic             clk,
    input logic             reset_n,
    input logic             clear,
    instr_encoder_if.slave  bus
);

    EncState         state;
    DpFields         held;
    logic [3:0]      rotK;
    logic [ADDR_W:0] wrCount;
    logic            wrEnQ;
    logic [31:0]     wrDataQ;
    logic            errQ;
    ErrCode          errCodeQ;

    logic            immHit;
    logic [7:0]      immByte;

    EncState         acceptState;
    ErrCode          acceptCode;
    logic [31:0]     acceptWord;

    imm_rot_check u_rotCheck (
        .imm32 (held.imm32),
        .k     (rotK),
        .hit   (immHit),
        .imm8  (immByte)
    );

    assign bus.in_ready = (state == ST_IDLE) && !clear;
    assign bus.wr_en    = wrEnQ;
    assign bus.wr_data  = wrDataQ;
    assign bus.wr_addr  = wrCount[ADDR_W-1:0];
    assign bus.full     = wrCount[ADDR_W];
    assign bus.err      = errQ;
    assign bus.err_code = errCodeQ;

    // Routing decision for a bundle presented in IDLE, checks in priority order
    always_comb begin
        acceptState = ST_EMIT;
        acceptCode  = ERR_BADOP;
        acceptWord  = '0;
        if (wrCount[ADDR_W]) begin
            acceptState = ST_ERR;
            acceptCode  = ERR_FULL;
        end else begin
            case (OpKind'(bus.op))
                OP_DP: begin
                    if (bus.use_imm) begin
                        acceptState = ST_SEARCH;
                    end else begin
                        acceptWord = encodeDp(bus.cond, 1'b0, bus.cmd, bus.s_bit,
                                              bus.rn, bus.rd, {8'h00, bus.rm});
                    end
                end
                OP_MEM: begin
                    if (|bus.imm32[31:12]) begin
                        acceptState = ST_ERR;
                        acceptCode  = ERR_RANGE;
                    end else begin
                        acceptWord = {bus.cond, MEM_CLASS, MEM_PUBW | {5'b00000, bus.ld},
                                      bus.rn, bus.rd, bus.imm32[11:0]};
                    end
                end
                OP_BR: begin
                    // Upper nine bits must all equal the sign bit of the 24-bit offset
                    if ((|bus.imm32[31:23]) && !(&bus.imm32[31:23])) begin
                        acceptState = ST_ERR;
                        acceptCode  = ERR_RANGE;
                    end else begin
                        acceptWord = {bus.cond, BR_FIXED, bus.imm32[23:0]};
                    end
                end
                default: begin
                    acceptState = ST_ERR;
                    acceptCode  = ERR_BADOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            held     <= '0;
            rotK     <= '0;
            wrCount  <= '0;
            wrEnQ    <= 1'b0;
            wrDataQ  <= '0;
            errQ     <= 1'b0;
            errCodeQ <= ERR_BADOP;
        end else if (clear) begin
            state   <= ST_IDLE;
            rotK    <= '0;
            wrCount <= '0;
            wrEnQ   <= 1'b0;
            errQ    <= 1'b0;
        end else begin
            wrEnQ <= 1'b0;
            errQ  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        held  <= '{cond: bus.cond, cmd: bus.cmd, sBit: bus.s_bit,
                                   rn: bus.rn, rd: bus.rd, imm32: bus.imm32};
                        rotK  <= '0;
                        state <= acceptState;
                        if (acceptState == ST_EMIT) begin
                            wrEnQ   <= 1'b1;
                            wrDataQ <= acceptWord;
                        end else if (acceptState == ST_ERR) begin
                            errQ     <= 1'b1;
                            errCodeQ <= acceptCode;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (immHit) begin
                        state   <= ST_EMIT;
                        wrEnQ   <= 1'b1;
                        wrDataQ <= encodeDp(held.cond, 1'b1, held.cmd, held.sBit,
                                            held.rn, held.rd, {rotK, immByte});
                    end else if (rotK == 4'd15) begin
                        state    <= ST_ERR;
                        errQ     <= 1'b1;
                        errCodeQ <= ERR_IMM;
                    end else begin
                        rotK <= rotK + 4'd1;
                    end
                end
                ST_EMIT: begin
                    wrCount <= wrCount + {{ADDR_W{1'b0}}, 1'b1};
                    state   <= ST_IDLE;
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed vectors with a queued scoreboard for instr_encoder
module tb_instr_encoder;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    int   cyc = 0;
    int   vecs = 0;
    int   miscompares = 0;
    int   tbAddr = 0;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string          name;
        bit             isErr;
        logic [31:0]    data;
        logic [1:0]     code;
        logic [AW-1:0]  addr;
        int             atCyc;
    } ExpEvent;

    ExpEvent expQ[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vecs++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        ExpEvent e;
        if (reset_n && (bus.wr_en || bus.err)) begin
            if (expQ.size() == 0) begin
                vecs++;
                miscompares++;
                $display("FAIL unexpected_output: wr_en=%0b err=%0b at cycle %0d, expected none",
                         bus.wr_en, bus.err, cyc);
            end else begin
                e = expQ.pop_front();
                check({e.name, " kind"}, 32'(bus.err), 32'(e.isErr));
                check({e.name, " both_strobes"}, 32'(bus.wr_en & bus.err), 32'd0);
                check({e.name, " cycle"}, 32'(cyc), 32'(e.atCyc));
                check({e.name, " wr_addr"}, 32'(bus.wr_addr), 32'(e.addr));
                if (e.isErr) check({e.name, " err_code"}, 32'(bus.err_code), 32'(e.code));
                else         check({e.name, " wr_data"}, bus.wr_data, e.data);
            end
        end
    end

    task automatic waitReady();
        for (int i = 0; i < 40 && !bus.in_ready; i++) @(negedge clk);
        if (!bus.in_ready) begin
            vecs++;
            miscompares++;
            $display("FAIL ready_timeout: in_ready=0 after 40 cycles, expected 1");
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] cond, input logic [3:0] cmd,
                         input logic sb, input logic ld, input logic ui,
                         input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [31:0] imm);
        bus.op = op; bus.cond = cond; bus.cmd = cmd; bus.s_bit = sb; bus.ld = ld;
        bus.use_imm = ui; bus.rd = rd; bus.rn = rn; bus.rm = rm; bus.imm32 = imm;
    endtask

    task automatic issue(input string nm, input logic [1:0] op, input logic [3:0] cond,
                         input logic [3:0] cmd, input logic sb, input logic ld, input logic ui,
                         input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [31:0] imm, input bit isErr, input logic [1:0] code,
                         input logic [31:0] data, input int lat);
        ExpEvent e;
        waitReady();
        drive(op, cond, cmd, sb, ld, ui, rd, rn, rm, imm);
        bus.in_valid = 1'b1;
        e.name  = nm;
        e.isErr = isErr;
        e.data  = data;
        e.code  = code;
        e.addr  = tbAddr[AW-1:0];
        e.atCyc = cyc + lat;
        expQ.push_back(e);
        if (!isErr) tbAddr++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 30 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            vecs++;
            miscompares++;
            $display("FAIL %s timeout: %0d events outstanding, expected 0", nm, expQ.size());
            expQ.delete();
        end
    endtask

    initial begin : stimulus
        int startCyc;
        bus.in_valid = 1'b0;
        drive(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset wr_en", 32'(bus.wr_en), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset err_code", 32'(bus.err_code), 32'd0);
        check("reset wr_data", bus.wr_data, 32'h0);
        check("reset wr_addr", 32'(bus.wr_addr), 32'd0);
        check("reset full", 32'(bus.full), 32'd0);

        //    name         op     cond   cmd   s     ld    imm   rd    rn    rm    imm32         err   code   data          lat
        issue("add_imm",   2'b00, 4'hE, 4'h4, 1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 32'h00000005, 1'b0, 2'b00, 32'hE2821005, 2);
        issue("mov_rot4",  2'b00, 4'hE, 4'hD, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 32'hFF000000, 1'b0, 2'b00, 32'hE3A004FF, 6);
        issue("dp_noimm",  2'b00, 4'hE, 4'h4, 1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 32'h00000101, 1'b1, 2'b01, 32'h0,        17);
        issue("ldr_range", 2'b01, 4'hE, 4'h0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 32'h00001000, 1'b1, 2'b10, 32'h0,        1);
        issue("br_range",  2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h00800000, 1'b1, 2'b10, 32'h0,        1);
        issue("bad_op",    2'b11, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0,        1'b1, 2'b00, 32'h0,        1);
        issue("add_reg",   2'b00, 4'hE, 4'h4, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 32'h0,        1'b0, 2'b00, 32'hE0821003, 1);
        issue("ldr",       2'b01, 4'hE, 4'h0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 32'h00000008, 1'b0, 2'b00, 32'hE5943008, 1);
        check("full after 4 writes", 32'(bus.full), 32'd1);
        issue("b_full",    2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFE, 1'b1, 2'b11, 32'h0,        1);

        // clear collides with a valid bundle: nothing may be accepted
        waitReady();
        drive(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFE);
        bus.in_valid = 1'b1;
        clear = 1'b1;
        #1;
        check("clear in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        tbAddr = 0;
        check("clear full", 32'(bus.full), 32'd0);
        check("clear wr_addr", 32'(bus.wr_addr), 32'd0);

        issue("b_neg",     2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFE, 1'b0, 2'b00, 32'hEAFFFFFE, 1);
        issue("str",       2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd4, 4'd0, 32'h00000008, 1'b0, 2'b00, 32'hE5843008, 1);
        issue("adds_rot14",2'b00, 4'hE, 4'h4, 1'b1, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 32'h000003F0, 1'b0, 2'b00, 32'hE2921E3F, 16);
        issue("mov_rot15", 2'b00, 4'hE, 4'hD, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 32'h000003FC, 1'b0, 2'b00, 32'hE3A00FFF, 17);

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        tbAddr = 0;

        // reset in the middle of a search that would otherwise match at k=4
        waitReady();
        drive(2'b00, 4'hE, 4'hD, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 32'hFF000000);
        bus.in_valid = 1'b1;
        startCyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (cyc < startCyc + 3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort wr_en", 32'(bus.wr_en), 32'd0);
        check("abort err", 32'(bus.err), 32'd0);
        check("abort err_code", 32'(bus.err_code), 32'd0);
        check("abort wr_data", bus.wr_data, 32'h0);
        check("abort wr_addr", 32'(bus.wr_addr), 32'd0);
        check("abort full", 32'(bus.full), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
